// File: rtl/sobel_window_ctrl.sv
// Raster-to-window sequencer for the 5x5 Sobel datapath: four line buffers,
// a 5x5 shifting window, frame position tracking and a latency-matched valid/coordinate pipeline.
module sobel_window_ctrl #(
  parameter int unsigned IMG_W     = 640,
  parameter int unsigned IMG_H     = 480,
  parameter int unsigned SOBEL_LAT = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [7:0]   pix_in,
  input  logic         pix_valid,
  output logic [199:0] matrix_out,
  output logic         win_valid,
  output logic         edge_valid,
  output logic [9:0]   edge_x,
  output logic [9:0]   edge_y,
  output logic         busy,
  output logic         frame_done
);

  localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned FW = $clog2(SOBEL_LAT + 3);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;
  state_t state, state_nxt;

  logic [9:0]    x, y;
  logic [XW-1:0] xi;
  logic [FW-1:0] flush_cnt;
  logic          accept, last_pix;

  logic [7:0] lb1 [IMG_W];
  logic [7:0] lb2 [IMG_W];
  logic [7:0] lb3 [IMG_W];
  logic [7:0] lb4 [IMG_W];
  logic [7:0] win [5][5];
  logic [199:0] packed_win;

  logic       acc_q, cmp_q;
  logic [9:0] ctr_x_q, ctr_y_q, win_x, win_y;
  logic       vpipe [SOBEL_LAT];
  logic [9:0] xpipe [SOBEL_LAT];
  logic [9:0] ypipe [SOBEL_LAT];

  always_comb begin
    xi       = x[XW-1:0];
    accept   = (state == ACTIVE) && pix_valid;
    last_pix = (x == 10'(IMG_W - 1)) && (y == 10'(IMG_H - 1));
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FLUSH covers the output register stage plus the datapath latency, so
  // frame_done lands the cycle after the final edge_valid.
  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = ACTIVE;
      ACTIVE: begin
        busy = 1'b1;
        if (accept && last_pix) state_nxt = FLUSH;
      end
      FLUSH:  begin
        if (flush_cnt == FW'(SOBEL_LAT + 2)) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x         <= '0;
      y         <= '0;
      flush_cnt <= '0;
    end else begin
      flush_cnt <= (state == FLUSH) ? flush_cnt + FW'(1) : '0;
      if (state == IDLE && start) begin
        x <= '0;
        y <= '0;
      end else if (accept) begin
        if (x == 10'(IMG_W - 1)) begin
          x <= '0;
          y <= last_pix ? '0 : y + 10'd1;
        end else begin
          x <= x + 10'd1;
        end
      end
    end
  end

  // Storage is never cleared; a window is only declared once it has been refilled.
  always_ff @(posedge clock) begin
    if (accept) begin
      lb1[xi] <= pix_in;
      lb2[xi] <= lb1[xi];
      lb3[xi] <= lb2[xi];
      lb4[xi] <= lb3[xi];
      for (int unsigned r = 0; r < 5; r++)
        for (int unsigned c = 0; c < 4; c++)
          win[r][c] <= win[r][c+1];
      win[0][4] <= lb4[xi];
      win[1][4] <= lb3[xi];
      win[2][4] <= lb2[xi];
      win[3][4] <= lb1[xi];
      win[4][4] <= pix_in;
    end
  end

  always_comb begin
    packed_win = '0;
    for (int unsigned r = 0; r < 5; r++)
      for (int unsigned c = 0; c < 5; c++)
        packed_win[8*(24-(5*r+c)) +: 8] = win[r][c];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q      <= 1'b0;
      cmp_q      <= 1'b0;
      ctr_x_q    <= '0;
      ctr_y_q    <= '0;
      matrix_out <= '0;
      win_valid  <= 1'b0;
      win_x      <= '0;
      win_y      <= '0;
    end else begin
      acc_q <= accept;
      cmp_q <= accept && (x >= 10'd4) && (y >= 10'd4);
      if (accept) begin
        ctr_x_q <= x - 10'd2;
        ctr_y_q <= y - 10'd2;
      end
      win_valid <= cmp_q;
      if (acc_q) matrix_out <= packed_win;
      win_x <= ctr_x_q;
      win_y <= ctr_y_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < SOBEL_LAT; i++) begin
        vpipe[i] <= 1'b0;
        xpipe[i] <= '0;
        ypipe[i] <= '0;
      end
    end else begin
      vpipe[0] <= win_valid;
      xpipe[0] <= win_x;
      ypipe[0] <= win_y;
      for (int unsigned i = 1; i < SOBEL_LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
        xpipe[i] <= xpipe[i-1];
        ypipe[i] <= ypipe[i-1];
      end
    end
  end

  always_comb begin
    edge_valid = vpipe[SOBEL_LAT-1];
    edge_x     = xpipe[SOBEL_LAT-1];
    edge_y     = ypipe[SOBEL_LAT-1];
  end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl on an 8x6 frame: window contents,
// coordinates, latency, gaps, ignored start, back-to-back frames and reset.
module tb_sobel_window_ctrl;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int LAT  = 3;
  localparam int MAXS = 512;

  logic         clock = 1'b0;
  logic         reset, start, pix_valid;
  logic [7:0]   pix_in;
  logic [199:0] matrix_out;
  logic         win_valid, edge_valid, busy, frame_done;
  logic [9:0]   edge_x, edge_y;

  int checks = 0;
  int errors = 0;

  sobel_window_ctrl #(.IMG_W(W), .IMG_H(H), .SOBEL_LAT(LAT)) dut (
    .clock(clock), .reset(reset), .start(start), .pix_in(pix_in),
    .pix_valid(pix_valid), .matrix_out(matrix_out), .win_valid(win_valid),
    .edge_valid(edge_valid), .edge_x(edge_x), .edge_y(edge_y),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  // per-negedge capture; s_dv[i] is the pix_valid driven right after sample i
  logic         s_wv [MAXS];
  logic         s_ev [MAXS];
  logic         s_fd [MAXS];
  logic         s_busy [MAXS];
  logic         s_dv [MAXS];
  logic [199:0] s_mat [MAXS];
  logic [9:0]   s_ex [MAXS];
  logic [9:0]   s_ey [MAXS];
  int           ns;

  logic [199:0] wq_mat [$];
  int           wq_t [$];
  logic [9:0]   eq_x [$];
  logic [9:0]   eq_y [$];
  int           eq_t [$];
  int           fd_t [$];

  function automatic logic [7:0] pix(input int kind, input int x, input int y);
    case (kind)
      0:       return 8'(16 * y + x);
      1:       return 8'd100;
      default: return (x < 4) ? 8'd0 : 8'd255;
    endcase
  endfunction

  function automatic logic [199:0] exp_win(input int kind, input int x, input int y);
    logic [199:0] m;
    m = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        m[8*(24-(5*r+c)) +: 8] = pix(kind, x - 4 + c, y - 4 + r);
    return m;
  endfunction

  task automatic cycle(input logic st, input logic v, input logic [7:0] p);
    @(negedge clock);
    if (ns < MAXS) begin
      s_wv[ns] = win_valid;  s_ev[ns] = edge_valid; s_fd[ns] = frame_done;
      s_busy[ns] = busy;     s_mat[ns] = matrix_out;
      s_ex[ns] = edge_x;     s_ey[ns] = edge_y;     s_dv[ns] = v;
      ns++;
    end
    start = st; pix_valid = v; pix_in = p;
  endtask

  task automatic run_frame(input int kind, input bit gaps, input int glitch_at);
    int idx;
    ns = 0; idx = 0;
    cycle(1'b1, 1'b0, 8'h00);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        if (gaps) begin
          if (idx % 5 == 2) cycle(1'b0, 1'b0, 8'hA5);
          for (int g = 0; g < 3 && $urandom_range(0, 1) == 0; g++)
            cycle(1'b0, 1'b0, 8'(g + 8'h5A));
        end
        cycle(idx == glitch_at, 1'b1, pix(kind, x, y));
        idx++;
      end
    repeat (12) cycle(1'b0, 1'b0, 8'h00);
    wq_mat.delete(); wq_t.delete(); eq_x.delete(); eq_y.delete(); eq_t.delete(); fd_t.delete();
    for (int i = 0; i < ns; i++) begin
      if (s_wv[i]) begin wq_mat.push_back(s_mat[i]); wq_t.push_back(i); end
      if (s_ev[i]) begin eq_x.push_back(s_ex[i]); eq_y.push_back(s_ey[i]); eq_t.push_back(i); end
      if (s_fd[i]) fd_t.push_back(i);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_in = '0;
    repeat (3) @(negedge clock);
    checks += 7;
    if (matrix_out !== '0) begin errors++; $display("FAIL reset_matrix: got %h expected 0", matrix_out); end
    if (win_valid !== 1'b0) begin errors++; $display("FAIL reset_win_valid: got %b expected 0", win_valid); end
    if (edge_valid !== 1'b0) begin errors++; $display("FAIL reset_edge_valid: got %b expected 0", edge_valid); end
    if (edge_x !== 10'd0) begin errors++; $display("FAIL reset_edge_x: got %0d expected 0", edge_x); end
    if (edge_y !== 10'd0) begin errors++; $display("FAIL reset_edge_y: got %0d expected 0", edge_y); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    reset = 1'b0;
  endtask

  task automatic test_ramp;
    run_frame(0, 1'b0, -1);
    checks += 3;
    if (wq_mat.size() != 8) begin errors++; $display("FAIL ramp_win_count: got %0d expected 8", wq_mat.size()); end
    if (eq_t.size() != 8) begin errors++; $display("FAIL ramp_edge_count: got %0d expected 8", eq_t.size()); end
    if (fd_t.size() != 1) begin errors++; $display("FAIL ramp_done_count: got %0d expected 1", fd_t.size()); end
    if (wq_mat.size() > 0) begin
      checks += 4;
      if (wq_mat[0][199:192] !== 8'h00) begin errors++; $display("FAIL ramp_z0: got %h expected 00", wq_mat[0][199:192]); end
      if (wq_mat[0][167:160] !== 8'h04) begin errors++; $display("FAIL ramp_z4: got %h expected 04", wq_mat[0][167:160]); end
      if (wq_mat[0][39:32] !== 8'h40) begin errors++; $display("FAIL ramp_z20: got %h expected 40", wq_mat[0][39:32]); end
      if (wq_mat[0][7:0] !== 8'h44) begin errors++; $display("FAIL ramp_z24: got %h expected 44", wq_mat[0][7:0]); end
    end
    for (int k = 0; k < wq_mat.size() && k < 8; k++) begin
      checks++;
      if (wq_mat[k] !== exp_win(0, 4 + k % 4, 4 + k / 4)) begin
        errors++; $display("FAIL ramp_window[%0d]: got %h expected %h", k, wq_mat[k], exp_win(0, 4 + k % 4, 4 + k / 4));
      end
    end
    for (int k = 0; k < eq_t.size() && k < 8 && k < wq_t.size(); k++) begin
      checks += 2;
      if (eq_x[k] !== 10'(2 + k % 4) || eq_y[k] !== 10'(2 + k / 4)) begin
        errors++; $display("FAIL ramp_coord[%0d]: got %0d/%0d expected %0d/%0d", k, eq_x[k], eq_y[k], 2 + k % 4, 2 + k / 4);
      end
      if (eq_t[k] != wq_t[k] + LAT) begin
        errors++; $display("FAIL ramp_edge_latency[%0d]: got %0d expected %0d", k, eq_t[k] - wq_t[k], LAT);
      end
    end
    if (fd_t.size() == 1 && eq_t.size() == 8) begin
      checks += 3;
      if (fd_t[0] != eq_t[7] + 1) begin errors++; $display("FAIL ramp_done_timing: got %0d expected %0d", fd_t[0], eq_t[7] + 1); end
      if (s_busy[fd_t[0]] !== 1'b0 || s_busy[fd_t[0]-1] !== 1'b1) begin
        errors++; $display("FAIL ramp_busy_fall: got %b%b expected 10", s_busy[fd_t[0]-1], s_busy[fd_t[0]]);
      end
      if (s_busy[0] !== 1'b0 || s_busy[1] !== 1'b1) begin
        errors++; $display("FAIL ramp_busy_rise: got %b%b expected 01", s_busy[0], s_busy[1]);
      end
    end
  endtask

  task automatic test_constant;
    run_frame(1, 1'b0, -1);
    checks++;
    if (wq_mat.size() != 8) begin errors++; $display("FAIL const_win_count: got %0d expected 8", wq_mat.size()); end
    for (int k = 0; k < wq_mat.size(); k++) begin
      checks++;
      if (wq_mat[k] !== {25{8'd100}}) begin errors++; $display("FAIL const_window[%0d]: got %h expected all 64", k, wq_mat[k]); end
    end
  endtask

  task automatic test_step;
    run_frame(2, 1'b0, -1);
    checks++;
    if (eq_t.size() != 8) begin errors++; $display("FAIL step_edge_count: got %0d expected 8", eq_t.size()); end
    for (int k = 0; k < eq_t.size() && k < 8; k++) begin
      checks++;
      if (eq_x[k] !== 10'(2 + k % 4)) begin errors++; $display("FAIL step_edge_x[%0d]: got %0d expected %0d", k, eq_x[k], 2 + k % 4); end
    end
    for (int k = 0; k < wq_mat.size() && k < 8; k++) begin
      checks += 2;
      if (wq_mat[k] !== exp_win(2, 4 + k % 4, 4 + k / 4)) begin
        errors++; $display("FAIL step_window[%0d]: got %h expected %h", k, wq_mat[k], exp_win(2, 4 + k % 4, 4 + k / 4));
      end
      if (wq_mat[k][199:192] !== 8'd0 || wq_mat[k][167:160] !== 8'd255) begin
        errors++; $display("FAIL step_straddle[%0d]: got z0=%h z4=%h expected 00/ff", k, wq_mat[k][199:192], wq_mat[k][167:160]);
      end
    end
  endtask

  task automatic test_gaps;
    int ngap;
    run_frame(0, 1'b1, -1);
    ngap = 0;
    for (int i = 0; i < ns; i++) if (!s_dv[i]) ngap++;
    checks += 2;
    if (ngap < 10) begin errors++; $display("FAIL gaps_present: got %0d expected >=10", ngap); end
    if (wq_mat.size() != 8) begin errors++; $display("FAIL gaps_win_count: got %0d expected 8", wq_mat.size()); end
    for (int k = 0; k < wq_mat.size() && k < 8; k++) begin
      checks += 2;
      if (wq_mat[k] !== exp_win(0, 4 + k % 4, 4 + k / 4)) begin
        errors++; $display("FAIL gaps_window[%0d]: got %h expected %h", k, wq_mat[k], exp_win(0, 4 + k % 4, 4 + k / 4));
      end
      if (wq_t[k] < 2 || s_dv[wq_t[k]-2] !== 1'b1) begin
        errors++; $display("FAIL gaps_win_in_gap[%0d]: got win_valid at sample %0d expected only after accepted pixel", k, wq_t[k]);
      end
    end
    for (int k = 0; k < eq_t.size() && k < 8 && k < wq_t.size(); k++) begin
      checks += 2;
      if (eq_x[k] !== 10'(2 + k % 4) || eq_y[k] !== 10'(2 + k / 4)) begin
        errors++; $display("FAIL gaps_coord[%0d]: got %0d/%0d expected %0d/%0d", k, eq_x[k], eq_y[k], 2 + k % 4, 2 + k / 4);
      end
      if (eq_t[k] != wq_t[k] + LAT) begin
        errors++; $display("FAIL gaps_edge_latency[%0d]: got %0d expected %0d", k, eq_t[k] - wq_t[k], LAT);
      end
    end
  endtask

  task automatic test_back_to_back;
    run_frame(0, 1'b0, 10);
    checks += 2;
    if (wq_mat.size() != 8) begin errors++; $display("FAIL b2b_glitch_win_count: got %0d expected 8", wq_mat.size()); end
    if (fd_t.size() != 1) begin errors++; $display("FAIL b2b_glitch_done_count: got %0d expected 1", fd_t.size()); end
    run_frame(0, 1'b0, -1);
    checks++;
    if (wq_mat.size() != 8) begin errors++; $display("FAIL b2b_second_win_count: got %0d expected 8", wq_mat.size()); end
    for (int k = 0; k < wq_mat.size() && k < 8; k++) begin
      checks++;
      if (wq_mat[k] !== exp_win(0, 4 + k % 4, 4 + k / 4)) begin
        errors++; $display("FAIL b2b_window[%0d]: got %h expected %h", k, wq_mat[k], exp_win(0, 4 + k % 4, 4 + k / 4));
      end
    end
  endtask

  task automatic test_reset_midframe;
    ns = 0;
    cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 8'(8'hC0 + i));
    @(negedge clock);
    reset = 1'b1; start = 1'b0; pix_valid = 1'b0;
    @(negedge clock);
    checks += 7;
    if (matrix_out !== '0) begin errors++; $display("FAIL midrst_matrix: got %h expected 0", matrix_out); end
    if (win_valid !== 1'b0) begin errors++; $display("FAIL midrst_win_valid: got %b expected 0", win_valid); end
    if (edge_valid !== 1'b0) begin errors++; $display("FAIL midrst_edge_valid: got %b expected 0", edge_valid); end
    if (edge_x !== 10'd0) begin errors++; $display("FAIL midrst_edge_x: got %0d expected 0", edge_x); end
    if (edge_y !== 10'd0) begin errors++; $display("FAIL midrst_edge_y: got %0d expected 0", edge_y); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL midrst_frame_done: got %b expected 0", frame_done); end
    reset = 1'b0;
    run_frame(0, 1'b0, -1);
    checks++;
    if (wq_mat.size() != 8) begin errors++; $display("FAIL midrst_win_count: got %0d expected 8", wq_mat.size()); end
    for (int k = 0; k < wq_mat.size() && k < 8; k++) begin
      checks++;
      if (wq_mat[k] !== exp_win(0, 4 + k % 4, 4 + k / 4)) begin
        errors++; $display("FAIL midrst_window[%0d]: got %h expected %h", k, wq_mat[k], exp_win(0, 4 + k % 4, 4 + k / 4));
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_constant();
    test_step();
    test_gaps();
    test_back_to_back();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
